// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames and
// tracks make/break codes of the most recently pressed key.
module ps2_scancode_rx #(
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [7:0]       scan_code,
  output logic             key_down,
  output logic             make_pulse,
  output logic             break_pulse,
  output logic             frame_err,
  output logic [CNT_W-1:0] press_count
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {S_IDLE, S_BREAK} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   fall, data_bit, frame_ok;
  logic [3:0]             bit_cnt;
  logic [9:0]             shift_reg;
  logic [TO_W-1:0]        timeout_cnt;
  logic                   byte_valid;
  logic [7:0]             byte_data;

  state_t                 state, state_next;
  logic [7:0]             scan_next;
  logic                   key_down_next, make_next, break_next;
  logic [CNT_W-1:0]       count_next;

  // Synchronisers reset to the idle-bus level so no spurious fall appears
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign fall     = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign data_bit = data_sync[SYNC_STAGES-2];
  // shift_reg holds start in bit 0, data in 8:1, parity in 9; stop is the live bit
  assign frame_ok = ~shift_reg[0] & (^shift_reg[9:1]) & data_bit;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      timeout_cnt <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      frame_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        timeout_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            byte_data  <= shift_reg[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt   <= bit_cnt + 4'd1;
          shift_reg <= {data_bit, shift_reg[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        if (timeout_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          frame_err   <= 1'b1;
          bit_cnt     <= '0;
          timeout_cnt <= '0;
        end else begin
          timeout_cnt <= timeout_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state       <= S_IDLE;
      scan_code   <= '0;
      key_down    <= 1'b0;
      make_pulse  <= 1'b0;
      break_pulse <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_next;
      scan_code   <= scan_next;
      key_down    <= key_down_next;
      make_pulse  <= make_next;
      break_pulse <= break_next;
      press_count <= count_next;
    end
  end

  always_comb begin
    state_next    = state;
    scan_next     = scan_code;
    key_down_next = key_down;
    make_next     = 1'b0;
    break_next    = 1'b0;
    count_next    = press_count;
    if (byte_valid) begin
      case (state)
        S_IDLE: begin
          if (byte_data == 8'hF0) begin
            state_next = S_BREAK;
          end else if (byte_data != 8'hE0) begin
            // A repeat of the held key is typematic and produces no event
            if (!key_down || byte_data != scan_code) begin
              scan_next     = byte_data;
              key_down_next = 1'b1;
              make_next     = 1'b1;
              count_next    = press_count + 1'b1;
            end
          end
        end
        S_BREAK: begin
          state_next = S_IDLE;
          if (byte_data == scan_code) begin
            scan_next     = 8'h00;
            key_down_next = 1'b0;
            break_next    = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end else if (frame_err && state == S_BREAK) begin
      state_next = S_IDLE;
    end
  end

endmodule
